// File: rtl/bt_frame_ctrl_pkg.sv
// bt_frame_ctrl_pkg
//   Shared definitions for the byte-frame controller: start-of-frame marker,
//   default inter-byte timeout, FSM state encoding and the frame checksum.
//   Frame layout on the wire: SOF, CMD, ARG, SUM with SUM = SOF+CMD+ARG mod 256.
package bt_frame_ctrl_pkg;

  localparam logic [7:0]  SOF             = 8'hAA;
  // About five byte times at 9600 baud with a 100 MHz clock.
  localparam logic [19:0] TIMEOUT_DEFAULT = 20'd520000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_CMD  = 3'd1,
    ST_GET_ARG  = 3'd2,
    ST_GET_SUM  = 3'd3,
    ST_DISPATCH = 3'd4
  } state_t;

  // Expected SUM byte for a frame carrying cmd_in/arg_in (modulo-256 add).
  function automatic logic [7:0] frame_sum(input logic [7:0] cmd_in,
                                           input logic [7:0] arg_in);
    return SOF + cmd_in + arg_in;
  endfunction

endpackage

// File: rtl/bt_timeout_timer.sv
// bt_timeout_timer
//   Inter-byte watchdog. Counts clock cycles while en is high; clr or a low en
//   restarts the count from zero. expired is high during the cycle in which
//   the count equals TIMEOUT-1, and the count restarts after that cycle.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-low reset
//   clr     - restart the count (a byte arrived)
//   en      - count enable (frame reception in progress)
//   expired - timeout reached this cycle
module bt_timeout_timer
  import bt_frame_ctrl_pkg::*;
#(
  parameter logic [19:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [19:0] count_r;
  logic        at_limit_s;

  // Terminal-count decode of the running count.
  always_comb begin
    at_limit_s = 1'b0;
    if (count_r == (TIMEOUT - 20'd1)) begin
      at_limit_s = 1'b1;
    end else begin
      at_limit_s = 1'b0;
    end
  end

  assign expired = en & at_limit_s;

  // Cycle counter: cleared by reset, clr, disable or expiry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= 20'd0;
    end else if (clr || !en || at_limit_s) begin
      count_r <= 20'd0;
    end else begin
      count_r <= count_r + 20'd1;
    end
  end

endmodule

// File: rtl/bt_frame_ctrl.sv
// bt_frame_ctrl
//   Parses SOF/CMD/ARG/SUM frames from a UART byte stream and presents the
//   validated command on a valid/ready interface. Checksum errors, inter-byte
//   timeouts and bytes arriving while a command waits are flagged as one-cycle
//   pulses and counted in a saturating error counter. All outputs registered.
// Ports:
//   clk, reset          - clock and synchronous active-low reset
//   rx_byte, rx_valid   - byte strobe from the UART receiver
//   cmd_ready           - consumer accepts cmd/arg
//   cmd_valid, cmd, arg - validated command presented
//   err_sum             - checksum mismatch pulse
//   err_timeout         - inter-byte timeout pulse
//   overrun             - byte dropped while dispatching
//   err_cnt             - saturating error-cycle count
//   busy                - FSM not in IDLE
module bt_frame_ctrl
  import bt_frame_ctrl_pkg::*;
#(
  parameter logic [19:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic       err_sum,
  output logic       err_timeout,
  output logic       overrun,
  output logic [7:0] err_cnt,
  output logic       busy
);

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] cmd_r;
  logic [7:0] arg_r;
  logic       cmd_valid_r;
  logic       err_sum_r;
  logic       err_timeout_r;
  logic       overrun_r;
  logic [7:0] err_cnt_r;
  logic       busy_r;

  logic       cmd_ld_s;
  logic       arg_ld_s;
  logic       err_sum_s;
  logic       err_timeout_s;
  logic       overrun_s;
  logic       err_any_s;
  logic       timer_en_s;
  logic       expired_s;

  // The timer only runs while a frame is partially received; a byte restarts it.
  always_comb begin
    timer_en_s = 1'b0;
    if ((state_r == ST_GET_CMD) || (state_r == ST_GET_ARG) ||
        (state_r == ST_GET_SUM)) begin
      timer_en_s = 1'b1;
    end else begin
      timer_en_s = 1'b0;
    end
  end

  bt_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (rx_valid),
    .en      (timer_en_s),
    .expired (expired_s)
  );

  // Next-state and event decode. A byte arriving on the expiry cycle is
  // processed and suppresses the timeout.
  always_comb begin
    next_state_s  = state_r;
    cmd_ld_s      = 1'b0;
    arg_ld_s      = 1'b0;
    err_sum_s     = 1'b0;
    err_timeout_s = 1'b0;
    overrun_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == SOF)) begin
          next_state_s = ST_GET_CMD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GET_CMD: begin
        // SOF value here is command data; no resynchronisation mid-frame.
        if (rx_valid) begin
          cmd_ld_s     = 1'b1;
          next_state_s = ST_GET_ARG;
        end else if (expired_s) begin
          err_timeout_s = 1'b1;
          next_state_s  = ST_IDLE;
        end else begin
          next_state_s = ST_GET_CMD;
        end
      end
      ST_GET_ARG: begin
        if (rx_valid) begin
          arg_ld_s     = 1'b1;
          next_state_s = ST_GET_SUM;
        end else if (expired_s) begin
          err_timeout_s = 1'b1;
          next_state_s  = ST_IDLE;
        end else begin
          next_state_s = ST_GET_ARG;
        end
      end
      ST_GET_SUM: begin
        if (rx_valid) begin
          if (rx_byte == frame_sum(cmd_r, arg_r)) begin
            next_state_s = ST_DISPATCH;
          end else begin
            err_sum_s    = 1'b1;
            next_state_s = ST_IDLE;
          end
        end else if (expired_s) begin
          err_timeout_s = 1'b1;
          next_state_s  = ST_IDLE;
        end else begin
          next_state_s = ST_GET_SUM;
        end
      end
      ST_DISPATCH: begin
        // Any byte here is dropped, including on the handshake cycle.
        overrun_s = rx_valid;
        if (cmd_valid_r && cmd_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DISPATCH;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  assign err_any_s = err_sum_s | err_timeout_s | overrun_s;

  // State, frame fields and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cmd_r         <= 8'h00;
      arg_r         <= 8'h00;
      cmd_valid_r   <= 1'b0;
      err_sum_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      overrun_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      cmd_r         <= cmd_ld_s ? rx_byte : cmd_r;
      arg_r         <= arg_ld_s ? rx_byte : arg_r;
      cmd_valid_r   <= (next_state_s == ST_DISPATCH);
      err_sum_r     <= err_sum_s;
      err_timeout_r <= err_timeout_s;
      overrun_r     <= overrun_s;
      busy_r        <= (next_state_s != ST_IDLE);
    end
  end

  // Saturating error counter; coincident events in one cycle count once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_r <= 8'h00;
    end else if (err_any_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign cmd_valid   = cmd_valid_r;
  assign cmd         = cmd_r;
  assign arg         = arg_r;
  assign err_sum     = err_sum_r;
  assign err_timeout = err_timeout_r;
  assign overrun     = overrun_r;
  assign err_cnt     = err_cnt_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_bt_frame_ctrl.sv
// tb_bt_frame_ctrl
//   Directed self-checking bench for bt_frame_ctrl with a short timeout.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_bt_frame_ctrl;

  localparam logic [19:0] TMO = 20'd16;

  logic       clk;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic       err_sum;
  logic       err_timeout;
  logic       overrun;
  logic [7:0] err_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;
  int hs_cnt   = 0;
  logic [7:0] exp_err = 8'h00;

  bt_frame_ctrl #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .arg         (arg),
    .err_sum     (err_sum),
    .err_timeout (err_timeout),
    .overrun     (overrun),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor.
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) hs_cnt++;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(2);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fails++; $display("FAIL reset_cmd_valid: got %b exp 0", cmd_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if ({cmd, arg} !== 16'h0000) begin n_fails++; $display("FAIL reset_cmd_arg: got %h exp 0000", {cmd, arg}); end
    n_checks++; if (err_cnt !== 8'h00) begin n_fails++; $display("FAIL reset_err_cnt: got %h exp 00", err_cnt); end
    n_checks++; if ({err_sum, err_timeout, overrun} !== 3'b000) begin n_fails++; $display("FAIL reset_flags: got %b exp 000", {err_sum, err_timeout, overrun}); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_good_frame;
    int hs0;
    cmd_ready = 1'b1;
    hs0 = hs_cnt;
    send_byte(8'h55);
    send_byte(8'h13);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL idle_garbage_busy: got %b exp 0", busy); end
    send_byte(8'hAA);
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL good_busy_after_sof: got %b exp 1", busy); end
    send_byte(8'h01);
    send_byte(8'h05);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fails++; $display("FAIL good_early_valid: got %b exp 0", cmd_valid); end
    send_byte(8'hB0);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fails++; $display("FAIL good_valid: got %b exp 1", cmd_valid); end
    n_checks++; if ({cmd, arg} !== 16'h0105) begin n_fails++; $display("FAIL good_cmd_arg: got %h exp 0105", {cmd, arg}); end
    tick(1);
    n_checks++; if ({cmd_valid, busy} !== 2'b00) begin n_fails++; $display("FAIL good_release: got %b exp 00", {cmd_valid, busy}); end
    n_checks++; if (hs_cnt - hs0 !== 1) begin n_fails++; $display("FAIL good_handshakes: got %0d exp 1", hs_cnt - hs0); end
    n_checks++; if (err_cnt !== exp_err) begin n_fails++; $display("FAIL good_err_cnt: got %h exp %h", err_cnt, exp_err); end
  endtask

  task automatic test_bad_sum;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h00);
    exp_err = exp_err + 8'd1;
    n_checks++; if (err_sum !== 1'b1) begin n_fails++; $display("FAIL badsum_pulse: got %b exp 1", err_sum); end
    n_checks++; if ({cmd_valid, busy} !== 2'b00) begin n_fails++; $display("FAIL badsum_valid_busy: got %b exp 00", {cmd_valid, busy}); end
    n_checks++; if (err_cnt !== exp_err) begin n_fails++; $display("FAIL badsum_err_cnt: got %h exp %h", err_cnt, exp_err); end
    tick(1);
    n_checks++; if (err_sum !== 1'b0) begin n_fails++; $display("FAIL badsum_one_cycle: got %b exp 0", err_sum); end
  endtask

  task automatic test_timeout;
    send_byte(8'hAA);
    send_byte(8'h02);
    tick(int'(TMO) - 1);
    n_checks++; if ({err_timeout, busy} !== 2'b01) begin n_fails++; $display("FAIL tmo_early: got %b exp 01", {err_timeout, busy}); end
    tick(1);
    exp_err = exp_err + 8'd1;
    n_checks++; if ({err_timeout, busy} !== 2'b10) begin n_fails++; $display("FAIL tmo_pulse: got %b exp 10", {err_timeout, busy}); end
    n_checks++; if (err_cnt !== exp_err) begin n_fails++; $display("FAIL tmo_err_cnt: got %h exp %h", err_cnt, exp_err); end
    tick(1);
    n_checks++; if (err_timeout !== 1'b0) begin n_fails++; $display("FAIL tmo_one_cycle: got %b exp 0", err_timeout); end
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'hAF);
    n_checks++; if ({cmd_valid, cmd, arg} !== 17'h10203) begin n_fails++; $display("FAIL tmo_recover: got %h exp 10203", {cmd_valid, cmd, arg}); end
    tick(1);
  endtask

  task automatic test_overrun;
    int hs0;
    cmd_ready = 1'b0;
    hs0 = hs_cnt;
    send_byte(8'hAA);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'hDA);
    tick(2);
    n_checks++; if ({cmd_valid, cmd, arg} !== 17'h11020) begin n_fails++; $display("FAIL ovr_hold: got %h exp 11020", {cmd_valid, cmd, arg}); end
    send_byte(8'h55);
    exp_err = exp_err + 8'd1;
    n_checks++; if (overrun !== 1'b1) begin n_fails++; $display("FAIL ovr_pulse: got %b exp 1", overrun); end
    n_checks++; if ({cmd_valid, cmd, arg} !== 17'h11020) begin n_fails++; $display("FAIL ovr_stable: got %h exp 11020", {cmd_valid, cmd, arg}); end
    n_checks++; if (err_cnt !== exp_err) begin n_fails++; $display("FAIL ovr_err_cnt: got %h exp %h", err_cnt, exp_err); end
    cmd_ready = 1'b1;
    tick(1);
    n_checks++; if ({cmd_valid, overrun, busy} !== 3'b000) begin n_fails++; $display("FAIL ovr_release: got %b exp 000", {cmd_valid, overrun, busy}); end
    n_checks++; if (hs_cnt - hs0 !== 1) begin n_fails++; $display("FAIL ovr_handshakes: got %0d exp 1", hs_cnt - hs0); end
  endtask

  task automatic test_byte_on_timeout;
    cmd_ready = 1'b1;
    send_byte(8'hAA);
    tick(int'(TMO) - 1);
    send_byte(8'h03);
    n_checks++; if ({err_timeout, busy} !== 2'b01) begin n_fails++; $display("FAIL bot_no_timeout: got %b exp 01", {err_timeout, busy}); end
    send_byte(8'h04);
    send_byte(8'hB1);
    n_checks++; if ({cmd_valid, cmd, arg} !== 17'h10304) begin n_fails++; $display("FAIL bot_frame: got %h exp 10304", {cmd_valid, cmd, arg}); end
    n_checks++; if (err_cnt !== exp_err) begin n_fails++; $display("FAIL bot_err_cnt: got %h exp %h", err_cnt, exp_err); end
    tick(1);
  endtask

  task automatic test_back_to_back;
    cmd_ready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h55);
    n_checks++; if ({cmd_valid, cmd, arg} !== 17'h1AA01) begin n_fails++; $display("FAIL b2b_sof_as_data: got %h exp 1AA01", {cmd_valid, cmd, arg}); end
    send_byte(8'hAA);
    exp_err = exp_err + 8'd1;
    n_checks++; if ({overrun, cmd_valid, busy} !== 3'b100) begin n_fails++; $display("FAIL b2b_hs_overrun: got %b exp 100", {overrun, cmd_valid, busy}); end
    n_checks++; if (err_cnt !== exp_err) begin n_fails++; $display("FAIL b2b_err_cnt: got %h exp %h", err_cnt, exp_err); end
    send_byte(8'h01);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL b2b_dropped_sof: got %b exp 0", busy); end
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h08);
    send_byte(8'hB9);
    n_checks++; if ({cmd_valid, cmd, arg} !== 17'h10708) begin n_fails++; $display("FAIL b2b_next_frame: got %h exp 10708", {cmd_valid, cmd, arg}); end
    tick(1);
  endtask

  task automatic test_reset_saturate;
    send_byte(8'hAA);
    send_byte(8'h01);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    exp_err = 8'h00;
    n_checks++; if ({busy, err_sum, err_timeout, overrun, cmd_valid} !== 5'b00000) begin n_fails++; $display("FAIL rst_mid_state: got %b exp 00000", {busy, err_sum, err_timeout, overrun, cmd_valid}); end
    n_checks++; if (err_cnt !== 8'h00) begin n_fails++; $display("FAIL rst_mid_err_cnt: got %h exp 00", err_cnt); end
    send_byte(8'h05);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rst_mid_idle_parse: got %b exp 0", busy); end
    tick(int'(TMO) + 2);
    n_checks++; if (err_cnt !== 8'h00) begin n_fails++; $display("FAIL rst_mid_no_error: got %h exp 00", err_cnt); end
    for (int i = 1; i <= 300; i++) begin
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h05);
      send_byte(8'h00);
      if (i == 254) begin
        n_checks++; if (err_cnt !== 8'hFE) begin n_fails++; $display("FAIL sat_254: got %h exp FE", err_cnt); end
      end
      if (i == 255) begin
        n_checks++; if (err_cnt !== 8'hFF) begin n_fails++; $display("FAIL sat_255: got %h exp FF", err_cnt); end
      end
    end
    n_checks++; if (err_cnt !== 8'hFF) begin n_fails++; $display("FAIL sat_300: got %h exp FF", err_cnt); end
    n_checks++; if (err_sum !== 1'b1) begin n_fails++; $display("FAIL sat_last_pulse: got %b exp 1", err_sum); end
  endtask

  initial begin
    reset     = 1'b0;
    rx_byte   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b0;
    tick(1);
    test_reset();
    test_good_frame();
    test_bad_sum();
    test_timeout();
    test_overrun();
    test_byte_on_timeout();
    test_back_to_back();
    test_reset_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
